// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants, ALU ops and pipeline register types
package mips_pkg;

  localparam int IMEM_BYTES = 128;
  localparam int DMEM_BYTES = 128;

  localparam logic [5:0] OP_RTYPE    = 6'd0;
  localparam logic [5:0] OP_J        = 6'd2;
  localparam logic [5:0] OP_BEQ      = 6'd4;
  localparam logic [5:0] OP_ADDIU    = 6'd9;
  localparam logic [5:0] OP_SPECIAL2 = 6'd28;
  localparam logic [5:0] OP_LW       = 6'd35;
  localparam logic [5:0] OP_SW       = 6'd43;

  localparam logic [5:0] FN_MADDU = 6'd1;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SRL,
    ALU_MULTU, ALU_MADDU, ALU_MFHI, ALU_MFLO
  } alu_op_e;

  typedef enum logic [1:0] {FWD_REG, FWD_MEM, FWD_WB} fwd_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [4:0]  shamt;
    alu_op_e     alu_op;
    logic        alu_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  dest;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  dest;
    logic        reg_write;
  } mem_wb_t;

endpackage

// File: rtl/mips_pipeline_cpu_hazard_unit.sv
// rtl/mips_pipeline_cpu_hazard_unit.sv - EX operand forwarding and load-use stall detection
module hazard_unit
  import mips_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic [4:0] ex_dest,
  input  logic [4:0] mem_dest,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_dest,
  input  logic       wb_reg_write,
  input  logic       branch_taken,
  output fwd_e       fwd_a,
  output fwd_e       fwd_b,
  output logic       stall
);
  logic load_use;

  function automatic fwd_e pick(input logic [4:0] src, input logic [4:0] md, input logic mw,
                                input logic [4:0] wd, input logic ww);
    if (mw && md != 5'd0 && md == src) return FWD_MEM;
    if (ww && wd != 5'd0 && wd == src) return FWD_WB;
    return FWD_REG;
  endfunction

  assign fwd_a = pick(ex_rs, mem_dest, mem_reg_write, wb_dest, wb_reg_write);
  assign fwd_b = pick(ex_rt, mem_dest, mem_reg_write, wb_dest, wb_reg_write);

  assign load_use = ex_mem_read && ex_dest != 5'd0 &&
                    ((id_uses_rs && id_rs == ex_dest) || (id_uses_rt && id_rt == ex_dest));

  // A taken branch squashes the dependent instruction, so no stall is needed.
  assign stall = load_use && !branch_taken;
endmodule

// File: rtl/mips_pipeline_cpu_mem.sv
// rtl/mips_pipeline_cpu_mem.sv - byte-wide little-endian memory and 32x32 register file
module mips_byte_mem
  import mips_pkg::*;
#(
  parameter int BYTES = 128
) (
  input  logic        clk,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  localparam int AW = $clog2(BYTES);

  logic [7:0]  mem_array [BYTES];
  logic [32:0] byte_addr [4];

  // Bytes outside the array read as zero and ignore writes.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) begin
      byte_addr[i] = {1'b0, addr} + 33'(i);
      if (byte_addr[i] < 33'(BYTES))
        rdata[8*i +: 8] = mem_array[byte_addr[i][AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_addr[i] < 33'(BYTES))
          mem_array[byte_addr[i][AW-1:0]] <= wdata[8*i +: 8];
      end
    end
  end
endmodule

module mips_regfile (
  input  logic        clk,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] file_array [32];

  // Write-through bypass lets ID see a value being written back this cycle.
  always_comb begin
    rd1 = file_array[ra1];
    rd2 = file_array[ra2];
    if (we && wa == ra1) rd1 = wd;
    if (we && wa == ra2) rd2 = wd;
    if (ra1 == 5'd0) rd1 = '0;
    if (ra2 == 5'd0) rd2 = '0;
  end

  always_ff @(posedge clk) begin
    if (we && wa != 5'd0) file_array[wa] <= wd;
  end
endmodule

// File: rtl/mips_pipeline_cpu.sv
// rtl/mips_pipeline_cpu.sv - five-stage MIPS-Lite core with forwarding, HI/LO and hazard handling
module mips_pipeline_cpu
  import mips_pkg::*;
(
  input logic clk,
  input logic rst
);
  logic [31:0] pc, pc_next, pc4, instr_IF, instr_ID;
  logic [5:0]  opcode, funct;
  logic [31:0] regFile_WD;
  logic        check_EX;
  if_id_t      if_id, if_id_next;
  id_ex_t      id_ex, id_ex_next;
  ex_mem_t     ex_mem, ex_mem_next;
  mem_wb_t     mem_wb, mem_wb_next;
  logic [31:0] hi, lo, hi_next, lo_next;
  logic [31:0] rs_data, rt_data, dmem_rdata, j_target, br_target;
  logic [31:0] op_a, op_b, alu_b;
  logic [63:0] product;
  logic        id_jump, id_uses_rs, id_uses_rt, stall, branch_taken;
  fwd_e        fwd_a, fwd_b;

  assign pc4 = pc + 32'd4;

  mips_byte_mem #(.BYTES(IMEM_BYTES)) InstrMem (
    .clk(clk), .we(1'b0), .addr(pc), .wdata(32'd0), .rdata(instr_IF)
  );

  assign instr_ID = if_id.instr;
  assign opcode   = instr_ID[31:26];
  assign funct    = instr_ID[5:0];
  assign j_target = {if_id.pc4[31:28], instr_ID[25:0], 2'b00};

  mips_regfile regFile (
    .clk(clk), .ra1(instr_ID[25:21]), .ra2(instr_ID[20:16]), .rd1(rs_data), .rd2(rt_data),
    .we(mem_wb.reg_write), .wa(mem_wb.dest), .wd(mem_wb.data)
  );

  always_comb begin
    id_ex_next        = '0;
    id_ex_next.pc4    = if_id.pc4;
    id_ex_next.rs_val = rs_data;
    id_ex_next.rt_val = rt_data;
    id_ex_next.imm    = {{16{instr_ID[15]}}, instr_ID[15:0]};
    id_ex_next.rs     = instr_ID[25:21];
    id_ex_next.rt     = instr_ID[20:16];
    id_ex_next.shamt  = instr_ID[10:6];
    id_jump    = 1'b0;
    id_uses_rs = 1'b0;
    id_uses_rt = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        id_ex_next.dest = instr_ID[15:11];
        case (funct)
          FN_ADD:   id_ex_next.alu_op = ALU_ADD;
          FN_SUB:   id_ex_next.alu_op = ALU_SUB;
          FN_AND:   id_ex_next.alu_op = ALU_AND;
          FN_OR:    id_ex_next.alu_op = ALU_OR;
          FN_SLT:   id_ex_next.alu_op = ALU_SLT;
          FN_SRL:   id_ex_next.alu_op = ALU_SRL;
          FN_MFHI:  id_ex_next.alu_op = ALU_MFHI;
          FN_MFLO:  id_ex_next.alu_op = ALU_MFLO;
          FN_MULTU: id_ex_next.alu_op = ALU_MULTU;
          default:  id_ex_next.alu_op = ALU_NOP;
        endcase
        id_ex_next.reg_write = id_ex_next.alu_op inside
          {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SRL, ALU_MFHI, ALU_MFLO};
        id_uses_rs = id_ex_next.alu_op inside
          {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_MULTU};
        id_uses_rt = id_uses_rs || id_ex_next.alu_op == ALU_SRL;
      end
      OP_SPECIAL2: begin
        if (funct == FN_MADDU) begin
          id_ex_next.alu_op = ALU_MADDU;
          id_uses_rs = 1'b1;
          id_uses_rt = 1'b1;
        end
      end
      OP_ADDIU, OP_LW: begin
        id_ex_next.alu_op    = ALU_ADD;
        id_ex_next.alu_src   = 1'b1;
        id_ex_next.reg_write = 1'b1;
        id_ex_next.mem_read  = opcode == OP_LW;
        id_ex_next.dest      = instr_ID[20:16];
        id_uses_rs = 1'b1;
      end
      OP_SW: begin
        id_ex_next.alu_op    = ALU_ADD;
        id_ex_next.alu_src   = 1'b1;
        id_ex_next.mem_write = 1'b1;
        id_uses_rs = 1'b1;
        id_uses_rt = 1'b1;
      end
      OP_BEQ: begin
        id_ex_next.branch = 1'b1;
        id_uses_rs = 1'b1;
        id_uses_rt = 1'b1;
      end
      OP_J:    id_jump = 1'b1;
      default: ;
    endcase
  end

  hazard_unit hazard (
    .id_rs(instr_ID[25:21]), .id_rt(instr_ID[20:16]),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(id_ex.mem_read), .ex_rs(id_ex.rs), .ex_rt(id_ex.rt), .ex_dest(id_ex.dest),
    .mem_dest(ex_mem.dest), .mem_reg_write(ex_mem.reg_write),
    .wb_dest(mem_wb.dest), .wb_reg_write(mem_wb.reg_write),
    .branch_taken(branch_taken), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall)
  );

  always_comb begin
    case (fwd_a)
      FWD_MEM: op_a = ex_mem.result;
      FWD_WB:  op_a = mem_wb.data;
      default: op_a = id_ex.rs_val;
    endcase
    case (fwd_b)
      FWD_MEM: op_b = ex_mem.result;
      FWD_WB:  op_b = mem_wb.data;
      default: op_b = id_ex.rt_val;
    endcase
  end

  assign alu_b        = id_ex.alu_src ? id_ex.imm : op_b;
  assign branch_taken = id_ex.branch && (op_a == op_b);
  assign br_target    = id_ex.pc4 + {id_ex.imm[29:0], 2'b00};
  assign product      = {32'd0, op_a} * {32'd0, op_b};

  always_comb begin
    ex_mem_next            = '0;
    ex_mem_next.store_data = op_b;
    ex_mem_next.dest       = id_ex.dest;
    ex_mem_next.reg_write  = id_ex.reg_write;
    ex_mem_next.mem_read   = id_ex.mem_read;
    ex_mem_next.mem_write  = id_ex.mem_write;
    hi_next = hi;
    lo_next = lo;
    case (id_ex.alu_op)
      ALU_ADD:   ex_mem_next.result = op_a + alu_b;
      ALU_SUB:   ex_mem_next.result = op_a - alu_b;
      ALU_AND:   ex_mem_next.result = op_a & alu_b;
      ALU_OR:    ex_mem_next.result = op_a | alu_b;
      ALU_SLT:   ex_mem_next.result = {31'd0, $signed(op_a) < $signed(alu_b)};
      ALU_SRL:   ex_mem_next.result = op_b >> id_ex.shamt;
      ALU_MFHI:  ex_mem_next.result = hi;
      ALU_MFLO:  ex_mem_next.result = lo;
      ALU_MULTU: {hi_next, lo_next} = product;
      ALU_MADDU: {hi_next, lo_next} = {hi, lo} + product;
      default:   ;
    endcase
  end

  mips_byte_mem #(.BYTES(DMEM_BYTES)) DataMem (
    .clk(clk), .we(ex_mem.mem_write), .addr(ex_mem.result),
    .wdata(ex_mem.store_data), .rdata(dmem_rdata)
  );

  always_comb begin
    mem_wb_next.data      = ex_mem.mem_read ? dmem_rdata : ex_mem.result;
    mem_wb_next.dest      = ex_mem.dest;
    mem_wb_next.reg_write = ex_mem.reg_write;
  end

  assign regFile_WD = mem_wb.data;
  assign check_EX   = stall;

  // Redirect priority: taken branch, then jump, then load-use hold.
  always_comb begin
    if_id_next.pc4   = pc4;
    if_id_next.instr = instr_IF;
    if (branch_taken)  pc_next = br_target;
    else if (id_jump)  pc_next = j_target;
    else if (stall)    pc_next = pc;
    else               pc_next = pc4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc     <= '0;
      if_id  <= '0;
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      pc <= pc_next;
      if (branch_taken || id_jump) if_id <= '0;
      else if (!stall)             if_id <= if_id_next;
      id_ex  <= (branch_taken || stall) ? '0 : id_ex_next;
      ex_mem <= ex_mem_next;
      mem_wb <= mem_wb_next;
      hi     <= hi_next;
      lo     <= lo_next;
    end
  end
endmodule

// File: tb/tb_mips_pipeline_cpu.sv
// tb/tb_mips_pipeline_cpu.sv - directed and randomized checks of mips_pipeline_cpu against an ISA model
module tb_mips_pipeline_cpu;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int stall_cnt = 0;
  logic [31:0] wd_log [0:199];
  logic [31:0] prog [$];
  logic [31:0] m_reg [32];
  logic [7:0]  m_mem [128];
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mips_pipeline_cpu dut (.clk(clk), .rst(rst));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int op, input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic start();
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      dut.InstrMem.mem_array[i] = 8'h00;
      dut.DataMem.mem_array[i]  = 8'h00;
    end
    for (int r = 0; r < 32; r++) dut.regFile.file_array[r] = 32'h0;
    prog.delete();
  endtask

  task automatic release_reset();
    foreach (prog[i])
      for (int b = 0; b < 4; b++) dut.InstrMem.mem_array[4*i+b] = prog[i][8*b +: 8];
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    stall_cnt = 0;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      cyc++;
      wd_log[cyc] = dut.regFile_WD;
      if (dut.check_EX === 1'b1) stall_cnt++;
    end
  endtask

  function automatic logic [31:0] ld(input int a);
    return {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
  endfunction

  function automatic logic [31:0] dut_word(input int a);
    return {dut.DataMem.mem_array[a+3], dut.DataMem.mem_array[a+2],
            dut.DataMem.mem_array[a+1], dut.DataMem.mem_array[a]};
  endfunction

  initial begin
    int kind, rs, rt, rd, sh, imm, prev_ld, exp_stalls;
    logic [31:0] w, v;
    logic [63:0] acc;
    logic rd_rs, rd_rt;

    // Reset state and sequential ALU
    start();
    check("reset_pc", dut.pc, 32'h0);
    check("reset_check_ex", {31'd0, dut.check_EX}, 32'h0);
    check("reset_instr_id", dut.instr_ID, 32'h0);
    check("reset_wd", dut.regFile_WD, 32'h0);
    dut.regFile.file_array[1] = 32'd5;
    dut.regFile.file_array[2] = 32'd3;
    prog.push_back(rtype(0, 1, 2, 3, 0, 32));
    prog.push_back(rtype(0, 1, 2, 4, 0, 34));
    release_reset();
    run(1);
    check("if_first_instr", dut.instr_ID, rtype(0, 1, 2, 3, 0, 32));
    check("if_pc", dut.pc, 32'd4);
    check("id_opcode", {26'd0, dut.opcode}, 32'd0);
    check("id_funct", {26'd0, dut.funct}, 32'd32);
    run(7);
    check("alu_wd_add", wd_log[4], 32'd8);
    check("alu_wd_sub", wd_log[5], 32'd2);
    check("alu_r3", dut.regFile.file_array[3], 32'd8);
    check("alu_r4", dut.regFile.file_array[4], 32'd2);
    check("alu_stalls", 32'(stall_cnt), 32'd0);

    // Asynchronous reset in mid-flight, then restart from PC 0
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    run(2);
    rst = 1'b0;
    #1;
    check("midrst_pc", dut.pc, 32'h0);
    check("midrst_instr_id", dut.instr_ID, 32'h0);
    check("midrst_wd", dut.regFile_WD, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    cyc = 0;
    run(6);
    check("midrst_restart_wd", wd_log[4], 32'd8);

    // Back-to-back forwarding
    start();
    prog.push_back(itype(9, 0, 1, 7));
    prog.push_back(rtype(0, 1, 1, 2, 0, 32));
    prog.push_back(rtype(0, 2, 1, 3, 0, 37));
    release_reset();
    run(10);
    check("fwd_r2", dut.regFile.file_array[2], 32'd14);
    check("fwd_r3", dut.regFile.file_array[3], 32'd15);
    check("fwd_wd_or", wd_log[6], 32'd15);
    check("fwd_stalls", 32'(stall_cnt), 32'd0);

    // Load-use stall
    start();
    dut.DataMem.mem_array[0] = 8'h0A;
    prog.push_back(itype(35, 0, 1, 0));
    prog.push_back(rtype(0, 1, 1, 2, 0, 32));
    release_reset();
    run(10);
    check("lu_stalls", 32'(stall_cnt), 32'd1);
    check("lu_wd_lw", wd_log[4], 32'd10);
    check("lu_wd_add", wd_log[6], 32'd20);
    check("lu_r2", dut.regFile.file_array[2], 32'd20);

    // Multiply path
    start();
    dut.regFile.file_array[1] = 32'hFFFF_FFFF;
    dut.regFile.file_array[2] = 32'd2;
    prog.push_back(rtype(0, 1, 2, 0, 0, 25));
    prog.push_back(rtype(0, 0, 0, 3, 0, 16));
    prog.push_back(rtype(0, 0, 0, 4, 0, 18));
    prog.push_back(rtype(28, 1, 2, 0, 0, 1));
    prog.push_back(rtype(0, 0, 0, 5, 0, 18));
    prog.push_back(rtype(0, 0, 0, 6, 0, 16));
    release_reset();
    run(12);
    check("mul_hi", dut.regFile.file_array[3], 32'd1);
    check("mul_lo", dut.regFile.file_array[4], 32'hFFFF_FFFE);
    check("maddu_lo", dut.regFile.file_array[5], 32'hFFFF_FFFC);
    check("maddu_hi", dut.regFile.file_array[6], 32'd3);

    // Branch and jump
    start();
    for (int r = 5; r <= 8; r++) dut.regFile.file_array[r] = 32'hDEAD_0000 + 32'(r);
    prog.push_back(itype(4, 0, 0, 2));
    prog.push_back(itype(9, 0, 5, 1));
    prog.push_back(itype(9, 0, 6, 2));
    prog.push_back({6'd2, 26'd8});
    prog.push_back(itype(9, 0, 7, 3));
    prog.push_back(32'h0);
    prog.push_back(32'h0);
    prog.push_back(32'h0);
    prog.push_back(itype(9, 0, 8, 9));
    release_reset();
    run(14);
    check("br_skip_r5", dut.regFile.file_array[5], 32'hDEAD_0005);
    check("br_skip_r6", dut.regFile.file_array[6], 32'hDEAD_0006);
    check("j_skip_r7", dut.regFile.file_array[7], 32'hDEAD_0007);
    check("j_target_r8", dut.regFile.file_array[8], 32'd9);
    check("brj_wd_before", wd_log[8], 32'd0);
    check("brj_wd_timing", wd_log[9], 32'd9);

    // SW/LW round trip with SRL and SLT
    start();
    dut.regFile.file_array[1] = 32'h8000_0010;
    prog.push_back(itype(43, 0, 1, 8));
    prog.push_back(itype(35, 0, 2, 8));
    prog.push_back(rtype(0, 0, 2, 3, 4, 2));
    prog.push_back(rtype(0, 2, 0, 4, 0, 42));
    release_reset();
    run(12);
    check("sw_bytes", dut_word(8), 32'h8000_0010);
    check("sw_byte8", {24'd0, dut.DataMem.mem_array[8]}, 32'h10);
    check("lw_r2", dut.regFile.file_array[2], 32'h8000_0010);
    check("srl_r3", dut.regFile.file_array[3], 32'h0800_0001);
    check("slt_r4", dut.regFile.file_array[4], 32'd1);
    check("swlw_stalls", 32'(stall_cnt), 32'd1);

    // Randomized straight-line programs against the ISA model
    for (int round = 0; round < 8; round++) begin
      start();
      m_reg[0] = 32'h0;
      dut.regFile.file_array[0] = $urandom();
      for (int r = 1; r < 32; r++) begin
        m_reg[r] = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 20));
        dut.regFile.file_array[r] = m_reg[r];
      end
      for (int i = 0; i < 128; i++) begin
        m_mem[i] = 8'($urandom());
        dut.DataMem.mem_array[i] = m_mem[i];
      end
      m_hi = 32'h0;
      m_lo = 32'h0;
      prev_ld = 0;
      exp_stalls = 0;
      for (int k = 0; k < 28; k++) begin
        kind = (k == 26) ? 7 : (k == 27) ? 8 : $urandom_range(0, 12);
        rs = $urandom_range(0, 7);
        rt = $urandom_range(0, 7);
        rd = $urandom_range(0, 7);
        sh = $urandom_range(0, 31);
        imm = $urandom_range(0, 65535);
        if (k == 26) rd = 9;
        if (k == 27) rd = 10;
        rd_rs = 1'b0;
        rd_rt = 1'b0;
        v = 32'h0;
        case (kind)
          0: begin w = rtype(0, rs, rt, rd, 0, 32); rd_rs = 1; rd_rt = 1; v = m_reg[rs] + m_reg[rt]; end
          1: begin w = rtype(0, rs, rt, rd, 0, 34); rd_rs = 1; rd_rt = 1; v = m_reg[rs] - m_reg[rt]; end
          2: begin w = rtype(0, rs, rt, rd, 0, 36); rd_rs = 1; rd_rt = 1; v = m_reg[rs] & m_reg[rt]; end
          3: begin w = rtype(0, rs, rt, rd, 0, 37); rd_rs = 1; rd_rt = 1; v = m_reg[rs] | m_reg[rt]; end
          4: begin w = rtype(0, rs, rt, rd, 0, 42); rd_rs = 1; rd_rt = 1;
                   v = ($signed(m_reg[rs]) < $signed(m_reg[rt])) ? 32'd1 : 32'd0; end
          5: begin w = rtype(0, 0, rt, rd, sh, 2); rs = 0; rd_rt = 1; v = m_reg[rt] >> sh; end
          6: begin w = rtype(0, rs, rt, 0, 0, 25); rd_rs = 1; rd_rt = 1; end
          7: begin w = rtype(0, 0, 0, rd, 0, 16); v = m_hi; end
          8: begin w = rtype(0, 0, 0, rd, 0, 18); v = m_lo; end
          9: begin w = rtype(28, rs, rt, 0, 0, 1); rd_rs = 1; rd_rt = 1; end
          10: begin w = itype(9, rs, rt, imm); rd_rs = 1;
                    v = m_reg[rs] + {{16{imm[15]}}, 16'(imm)}; end
          11: begin imm = 4 * $urandom_range(0, 31); rs = 0; w = itype(35, 0, rt, imm); v = ld(imm); end
          default: begin imm = 4 * $urandom_range(0, 31); rs = 0; w = itype(43, 0, rt, imm);
                         rd_rs = 1; rd_rt = 1; end
        endcase
        if (prev_ld != 0 && ((rd_rs && rs == prev_ld) || (rd_rt && rt == prev_ld))) exp_stalls++;
        case (kind)
          0, 1, 2, 3, 4, 5, 7, 8: if (rd != 0) m_reg[rd] = v;
          10, 11: if (rt != 0) m_reg[rt] = v;
          6: {m_hi, m_lo} = 64'(m_reg[rs]) * 64'(m_reg[rt]);
          9: begin
            acc = {m_hi, m_lo} + 64'(m_reg[rs]) * 64'(m_reg[rt]);
            {m_hi, m_lo} = acc;
          end
          default: for (int b = 0; b < 4; b++) m_mem[imm+b] = m_reg[rt][8*b +: 8];
        endcase
        prev_ld = (kind == 11) ? rt : 0;
        prog.push_back(w);
      end
      release_reset();
      run(60);
      for (int r = 1; r < 32; r++)
        check($sformatf("rnd%0d_reg%0d", round, r), dut.regFile.file_array[r], m_reg[r]);
      for (int a = 0; a < 128; a += 4)
        check($sformatf("rnd%0d_mem%0d", round, a), dut_word(a), ld(a));
      check($sformatf("rnd%0d_stalls", round), 32'(stall_cnt), 32'(exp_stalls));
      check($sformatf("rnd%0d_past_imem", round), dut.instr_ID, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mips_pipeline_cpu.md
# mips_pipeline_cpu

Five-stage (IF/ID/EX/MEM/WB) pipelined MIPS-Lite CPU core with internal instruction memory, data memory, register file and HI/LO registers. It is the top of the CPU design; the only external pins are clock and reset. Program, data and register contents are preloaded by the bench through hierarchical paths. It executes ADD, SUB, AND, OR, SLT, SRL, MULTU, MFHI, MFLO, MADDU, ADDIU, LW, SW, BEQ and J, with forwarding and hazard handling.

## Interface
- Parameters: none. Memory sizes are fixed constants in the package: IMEM_BYTES=128, DMEM_BYTES=128.
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Reset, asynchronous and active-low.
- Required hierarchical names, read and preloaded by the bench:
  - InstrMem.mem_array, DataMem.mem_array: byte arrays, little-endian, one byte per entry.
  - regFile.file_array: 32×32-bit array.
  - pc, instr_ID, opcode, funct, regFile_WD, check_EX.

## Operation
- Encodings, all opcode 0 unless stated:
  - ADD funct 32, SUB 34, AND 36, OR 37, SLT 42 (signed), SRL 2 (rd = rt >> shamt, logical).
  - MULTU 25: {HI,LO} = rs×rt, unsigned 64-bit.
  - MFHI 16, MFLO 18.
  - MADDU: opcode 28, funct 1. {HI,LO} += rs×rt, unsigned, modulo 2^64.
  - LW 35, SW 43, BEQ 4, J 2, ADDIU 9 (rt = rs + sext(imm)).
- Overflow never traps; all adds and subtracts wrap.
- The all-zero word is a NOP.
- Unknown encodings execute as NOP.
- LW/SW address = rs + sext(imm). Words are assembled little-endian from 4 bytes.
- Branch and jump targets:
  - BEQ: PC+4+(sext(imm)<<2).
  - J: {PC+4[31:28], idx, 2'b00}.
- Register file:
  - $0 always reads 0; writes to $0 are ignored.
  - Writes occur at the WB clock edge.
  - A same-cycle read of the written register returns the new value (internal bypass).
- Forwarding to EX operands: EX/MEM result has priority over MEM/WB result. The register number must be nonzero and RegWrite must be set.
- HI/LO are updated at the end of EX. An immediately following MFHI/MFLO/MADDU sees the new value without a stall.
- Load-use hazard:
  - Condition: instruction in ID reads the rt of an LW currently in EX.
  - Action: stall PC and IF/ID for 1 cycle and insert an all-zero bubble into ID/EX.
  - check_EX is 1 during that cycle, 0 otherwise.
- Control hazards, static predict-not-taken:
  - J is resolved in ID; the IF instruction is squashed (1 bubble).
  - BEQ is resolved in EX; when taken, IF/ID and ID/EX are squashed to zero (2 bubbles).
  - A simultaneous load-use stall and taken branch: the branch flush wins.
- Observable signals:
  - opcode/funct are decoded from instr_ID.
  - regFile_WD is the WB-stage write data.

## Timing
- Reset (rst low):
  - pc = 0, all pipeline registers = 0, HI = LO = 0, check_EX = 0.
  - Register file and memories are not cleared; they keep their preloaded contents.
- First instruction at PC 0:
  - Fetched in the first rising edge after rst rises.
  - Reaches WB 4 cycles later.
- Throughput is 1 instruction per cycle except:
  - +1 cycle per load-use stall.
  - +1 cycle per J.
  - +2 cycles per taken BEQ.
- SW writes data memory at the end of MEM.
- LW data is written back at the end of WB.
- PC beyond IMEM_BYTES fetches zeros, i.e. NOPs.
- Reset asserted mid-execution: pipeline state is discarded immediately and fetch restarts at PC 0.

## Structure
- Shared package mips_pkg holds:
  - Opcode and funct constants.
  - ALU-op enum.
  - IMEM_BYTES and DMEM_BYTES.
  - Pipeline-register structs: IF_ID, ID_EX, EX_MEM, MEM_WB.
- Sub-modules, instance names fixed: InstrMem, DataMem, regFile.
- A separate hazard_unit sub-module holds forwarding and stall/flush logic. The ALU and HI/LO logic stay inline.

## Test plan
- Reset and sequential ALU:
  - Stimulus: preload $1=5, $2=3; run ADD $3,$1,$2 then SUB $4,$1,$2.
  - Response: regFile_WD = 8 then 2; no bubbles.
- Back-to-back forwarding:
  - Stimulus: ADDIU $1,$0,7; ADD $2,$1,$1; OR $3,$2,$1.
  - Response: $2 = 14, $3 = 15, no stall.
- Load-use:
  - Stimulus: mem[0] = 0x0000000A; LW $1,0($0); ADD $2,$1,$1.
  - Response: check_EX = 1 for exactly 1 cycle; $2 = 20.
- Multiply path:
  - Stimulus: $1 = 0xFFFFFFFF, $2 = 2; MULTU $1,$2; MFHI $3; MFLO $4; MADDU $1,$2; MFLO $5.
  - Response: $3 = 1, $4 = 0xFFFFFFFE, $5 = 0xFFFFFFFC.
- Branch and jump:
  - Stimulus: BEQ $0,$0,+2 followed by two ADDIUs, then J to PC 0x20.
  - Response: skipped instructions never write back; 2 bubbles after BEQ, 1 after J.
- SW/LW round trip with SLT/SRL:
  - Stimulus: SW 0x80000010 to byte address 8; LW it back; SRL by 4; SLT against 0.
  - Response: DataMem bytes 8..11 = 10 00 00 80; SRL result 0x08000001; SLT of 0x80000010 < 0 = 1.
